// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: operand and
// product widths and the controller state encoding.
package mult_pkg;

    localparam int MULT_WIDTH  = 8;
    localparam int MULT_PWIDTH = 2 * MULT_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/mult_add_stage.sv
// Combinational WIDTH-bit adder used for the accumulate step A + M.
// The carry out is kept separately so the caller can form a WIDTH+1-bit sum.
module mult_add_stage
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Zero-extend both operands by one bit so the carry is captured exactly.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier with a start/busy/done handshake.
// One add-and-shift iteration per clock; the double-width product is
// registered and held until the next completion.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave RUN as soon as the
// remaining multiplier bits are all zero, finishing the remaining shifts
// in one step. Results are identical to the default build.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             c_next;
    logic [WIDTH-1:0] a_acc;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] q_shift;
    logic             last_iter;

    mult_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (a_reg),
        .b    (m_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // One iteration: conditional accumulate on Q[0], then shift {C,A,Q} right.
    // C is always zero between iterations, so it lives only as c_next here.
    always_comb begin
        if (q_reg[0]) begin
            c_next = add_cout;
            a_acc  = add_sum;
        end else begin
            c_next = 1'b0;
            a_acc  = a_reg;
        end
        a_shift   = {c_next, a_acc[WIDTH-1:1]};
        q_shift   = {a_acc[0], q_reg[WIDTH-1:1]};
        last_iter = (count == CW'(1));
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH-1:0]   pend_mask;
    logic               early_stop;
    logic [2*WIDTH-1:0] early_prod;

    // The low count bits of Q are the multiplier bits still to be consumed;
    // when they are all zero the remaining iterations are pure shifts.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(count)) begin
                pend_mask[i] = 1'b1;
            end
        end
        early_stop = ((q_reg & pend_mask) == '0);
        early_prod = {a_reg, q_reg} >> count;
    end
`endif

    // Controller, datapath registers and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
                    if (early_stop) begin
                        product <= early_prod;
                        count   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else
`endif
                    begin
                        a_reg <= a_shift;
                        q_reg <= q_shift;
                        count <= count - CW'(1);
                        if (last_iter) begin
                            product <= {a_shift, q_shift};
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: a cycle-level behavioural model
// derived from the handshake timing and plain multiplication, compared every
// cycle, plus directed operations with literal expected results.
module tb_seq_shift_add_mult;

    localparam int W = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    int cyc      = 0;

    seq_shift_add_mult #(
        .WIDTH (W)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Number of RUN cycles an operation with multiplier q takes.
    function automatic int run_len(input logic [W-1:0] q);
        int p;
        p = -1;
        for (int i = 0; i < W; i++) begin
            if (q[i]) p = i;
        end
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (p < 0) return 1;
        return (p + 2 < W) ? p + 2 : W;
`else
        return W;
`endif
    endfunction

    // Behavioural model: remaining-RUN-cycle counter plus the exact product.
    int             m_left = 0;
    bit             m_busy = 0;
    bit             m_done = 0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_pend = '0;

    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            m_busy = 0;
            m_done = 0;
            m_prod = '0;
            m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_prod = m_pend;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            m_pend = (2*W)'(multiplicand) * (2*W)'(multiplier);
            m_left = run_len(multiplier);
            m_busy = 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_busy",    32'(busy),    32'(m_busy));
            check("model_done",    32'(done),    32'(m_done));
            check("model_product", 32'(product), 32'(m_prod));
        end
    end

    task automatic wait_done(output bit seen, output int bc);
        seen = 0;
        bc   = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy === 1'b1) bc++;
            @(negedge CLK);
        end
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp_p, input int exp_cyc);
        bit seen;
        int bc;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done(seen, bc);
        check("done_seen",  32'(seen),    32'd1);
        check("product",    32'(product), 32'(exp_p));
        check("run_cycles", bc,           exp_cyc);
        @(negedge CLK);
    endtask

    initial begin
        bit             seen;
        int             bc;
        int             t1;
        logic [W-1:0]   rm;
        logic [W-1:0]   rq;
        logic [2*W-1:0] rp;

        RESET        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET  = 1'b0;
        chk_en = 1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            check("rst_busy",    32'(busy),    32'd0);
            check("rst_done",    32'(done),    32'd0);
            check("rst_product", 32'(product), 32'h0000);
            @(negedge CLK);
        end

        // Basic and carry-stress operations
        run_op(8'd13,  8'd11,  16'h008F, run_len(8'd11));
        run_op(8'd255, 8'd255, 16'hFE01, run_len(8'd255));
        run_op(8'h80,  8'h02,  16'h0100, run_len(8'h02));
        run_op(8'd0,   8'd200, 16'h0000, run_len(8'd200));
        run_op(8'd200, 8'd0,   16'h0000, run_len(8'd0));
        run_op(8'd3,   8'h80,  16'h0180, 8);

        // start held through RUN/DONE with changed operands
        multiplicand = 8'd13;
        multiplier   = 8'd11;
        start        = 1'b1;
        @(negedge CLK);
        multiplicand = 8'd3;
        multiplier   = 8'd3;
        wait_done(seen, bc);
        check("held_done1_seen", 32'(seen),    32'd1);
        check("held_product1",   32'(product), 32'd143);
        t1 = cyc;
        @(negedge CLK);
        @(negedge CLK);
        start = 1'b0;
        wait_done(seen, bc);
        check("held_done2_seen", 32'(seen),    32'd1);
        check("held_product2",   32'(product), 32'd9);
        check("held_done_gap",   cyc - t1,     run_len(8'd3) + 2);
        @(negedge CLK);

        // Reset on the 4th RUN edge aborts the operation
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        start        = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_busy",    32'(busy),    32'd0);
        check("abort_done",    32'(done),    32'd0);
        check("abort_product", 32'(product), 32'h0000);
        repeat (10) @(negedge CLK);
        check("abort_no_done", 32'(done),    32'd0);
        run_op(8'd7, 8'd6, 16'd42, run_len(8'd6));

`ifdef SEQ_MULT_EARLY_TERM_EN
        run_op(8'd55,  8'd0, 16'd0,   1);
        run_op(8'd200, 8'd1, 16'd200, 2);
`endif

        // Random operand pairs against plain multiplication
        for (int i = 0; i < 64; i++) begin
            rm = W'($urandom_range(0, 255));
            rq = W'($urandom_range(0, 255));
            rp = (2*W)'(rm) * (2*W)'(rq);
            run_op(rm, rq, rp, run_len(rq));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
